// File: rtl/river_crossing_fsm.sv
// Missionaries-and-cannibals river crossing referee: validates boat moves, tracks both banks and the outcome.
// Optional build macro RC_STRICT_REJECT_EN: when defined, unsafe moves are rejected instead of ending the game as LOST.
module river_crossing_fsm #(
   parameter int N   = 3,
   parameter int CAP = 2,
   localparam int W  = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         restart,
   input  logic         move_valid,
   input  logic [W-1:0] move_m,
   input  logic [W-1:0] move_c,
   output logic         move_ready,
   output logic         move_accept,
   output logic         move_reject,
   output logic [W-1:0] missionary_left,
   output logic [W-1:0] cannibal_left,
   output logic         boat_side,
   output logic [1:0]   state,
   output logic [7:0]   move_count
);

   localparam logic [1:0]   ST_PLAY = 2'b00;
   localparam logic [1:0]   ST_WON  = 2'b01;
   localparam logic [1:0]   ST_LOST = 2'b10;
   localparam logic [W-1:0] N_W     = W'(N);
   localparam logic [W:0]   CAP_W   = (W + 1)'(CAP);

   logic [W-1:0] m_left_r;
   logic [W-1:0] c_left_r;
   logic         boat_r;
   logic [1:0]   state_r;
   logic [7:0]   count_r;
   logic         accept_r;
   logic         reject_r;

   logic [W-1:0] src_m_s;
   logic [W-1:0] src_c_s;
   logic [W-1:0] new_m_s;
   logic [W-1:0] new_c_s;
   logic [W:0]   sum_s;
   logic         form_bad_s;
   logic         supply_bad_s;
   logic         unsafe_s;
   logic         win_s;
   logic         take_s;

   // A bank is lost when its missionaries are present but outnumbered.
   function automatic logic bank_unsafe(input logic [W-1:0] m, input logic [W-1:0] c);
      return (m != {W{1'b0}}) && (c > m);
   endfunction

   // Evaluate the requested move against the current position.
   always_comb begin
      src_m_s = m_left_r;
      src_c_s = c_left_r;
      new_m_s = m_left_r;
      new_c_s = c_left_r;
      if (boat_r) begin
         src_m_s = N_W - m_left_r;
         src_c_s = N_W - c_left_r;
         new_m_s = m_left_r + move_m;
         new_c_s = c_left_r + move_c;
      end else begin
         new_m_s = m_left_r - move_m;
         new_c_s = c_left_r - move_c;
      end
      sum_s        = {1'b0, move_m} + {1'b0, move_c};
      form_bad_s   = (sum_s == {(W + 1){1'b0}}) || (sum_s > CAP_W);
      supply_bad_s = (move_m > src_m_s) || (move_c > src_c_s);
      unsafe_s     = bank_unsafe(new_m_s, new_c_s) ||
                     bank_unsafe(N_W - new_m_s, N_W - new_c_s);
      win_s        = !boat_r && (new_m_s == {W{1'b0}}) && (new_c_s == {W{1'b0}});
      take_s       = move_valid && (state_r == ST_PLAY);
   end

   // Game position, outcome and one-cycle result pulses.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         m_left_r <= N_W;
         c_left_r <= N_W;
         boat_r   <= 1'b0;
         state_r  <= ST_PLAY;
         count_r  <= 8'd0;
         accept_r <= 1'b0;
         reject_r <= 1'b0;
      end else begin
         accept_r <= 1'b0;
         reject_r <= 1'b0;
         if (take_s) begin
`ifdef RC_STRICT_REJECT_EN
            if (form_bad_s || supply_bad_s || unsafe_s) begin
`else
            if (form_bad_s || supply_bad_s) begin
`endif
               reject_r <= 1'b1;
            end else begin
               accept_r <= 1'b1;
               m_left_r <= new_m_s;
               c_left_r <= new_c_s;
               boat_r   <= ~boat_r;
               if (count_r != 8'hFF) begin
                  count_r <= count_r + 8'd1;
               end else begin
                  count_r <= count_r;
               end
               case (1'b1)
                  unsafe_s: state_r <= ST_LOST;
                  win_s:    state_r <= ST_WON;
                  default:  state_r <= ST_PLAY;
               endcase
            end
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign move_ready      = (state_r == ST_PLAY);
   assign move_accept     = accept_r;
   assign move_reject     = reject_r;
   assign missionary_left = m_left_r;
   assign cannibal_left   = c_left_r;
   assign boat_side       = boat_r;
   assign state           = state_r;
   assign move_count      = count_r;

endmodule

// File: doc/river_crossing_fsm.md
RIVER_CROSSING_FSM -- requirements
Module: river_crossing_fsm

Interface
REQ-001 Parameter N, default 3: number of missionaries and of cannibals; legal range 1..15.
REQ-002 Parameter CAP, default 2: boat capacity in persons; legal range 1..N*2.
REQ-003 Local width W = clog2(N+1) applies to every person-count port.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 restart  input  1  synchronous return to the start position from any state.
REQ-007 move_valid  input  1  a move request is present this cycle.
REQ-008 move_m  input  W  number of missionaries on the boat for the requested move.
REQ-009 move_c  input  W  number of cannibals on the boat for the requested move.
REQ-010 move_ready  output  1  high only in PLAY; a request is sampled only when move_valid and move_ready are both high.
REQ-011 move_accept  output  1  one-cycle pulse on the cycle after an accepted request.
REQ-012 move_reject  output  1  one-cycle pulse on the cycle after a rejected request.
REQ-013 missionary_left  output  W  missionaries on the left bank.
REQ-014 cannibal_left  output  W  cannibals on the left bank.
REQ-015 boat_side  output  1  boat position: 0 = left bank, 1 = right bank.
REQ-016 state  output  2  encoding: PLAY=00, WON=01, LOST=10.
REQ-017 move_count  output  8  count of accepted moves.

Function
REQ-018 Right-bank counts are derived as N-missionary_left and N-cannibal_left.
REQ-019 The source bank is the left bank when boat_side=0 and the right bank when boat_side=1.
REQ-020 Form check: a move is malformed if move_m+move_c is 0 or greater than CAP.
REQ-021 Supply check: a move is malformed if move_m or move_c exceeds the count on the source bank.
REQ-022 A malformed move is always rejected with no change to any state, count or position.
REQ-023 Sum arithmetic uses W+1 bits, so the form check cannot overflow.
REQ-024 A resulting bank is unsafe if it holds at least one missionary and more cannibals than missionaries.
REQ-025 A move is unsafe if either resulting bank is unsafe; handling of unsafe moves is fixed by REQ-041/042.
REQ-026 Accepted move: boat_side toggles.
REQ-027 Accepted move: left-bank counts decrease by (move_m, move_c) when boat_side was 0, and increase by them when boat_side was 1.
REQ-028 Accepted move: move_count increments and saturates at 255.
REQ-029 Latency: bank counts, boat_side and state are updated in the same edge that samples the request.
REQ-030 Latency: move_accept or move_reject is asserted in the following cycle, for exactly one cycle.
REQ-031 PLAY->WON when an accepted move leaves the left bank 0/0 with boat_side=1.
REQ-032 PLAY->LOST only as defined in REQ-042.
REQ-033 WON and LOST are absorbing: move_ready=0, requests are ignored, and no pulses are generated.
REQ-034 restart, in any state: load the start position and go to PLAY; a move_valid in the same cycle is ignored.
REQ-035 Back-to-back requests on consecutive cycles are each evaluated against the state updated by the previous edge.

Reset
REQ-036 reset has priority over restart and over move_valid.
REQ-037 reset mid-operation discards any pending accept/reject pulse.
REQ-038 Reset and start position for bank and boat outputs: missionary_left=N, cannibal_left=N, boat_side=0.
REQ-039 Reset and start position for status outputs: state=PLAY, move_count=0, move_accept=0, move_reject=0, move_ready=1 from the first cycle after reset.

Configuration
REQ-040 Macro RC_STRICT_REJECT_EN selects how unsafe moves are handled.
REQ-041 With RC_STRICT_REJECT_EN defined: an unsafe move is rejected like a malformed move and state stays PLAY.
REQ-042 Without RC_STRICT_REJECT_EN: an unsafe move is accepted (move_accept pulses, counts and move_count update) and state goes to LOST.

Verification
REQ-043 Reset, N=3 -> missionary_left=3, cannibal_left=3, boat_side=0, state=PLAY, move_ready=1, move_count=0.
REQ-044 N=3, CAP=2, 11-move classic solution (0,2)(0,1)(0,2)(0,1)(2,0)(1,1)(2,0)(0,1)(0,2)(0,1)(0,2) -> 11 accept pulses, final 0/0, boat_side=1, state=WON, move_count=11.
REQ-045 From start, (3,0) with CAP=2, then (0,0), then (0,3) with CAP=3 (3 cannibals requested, 3 on left bank) -> first two rejected with state unchanged; third is safe and accepted.
REQ-046 From start, (2,0): strict build -> reject, state PLAY, position 3/3; non-strict build -> accept, left bank 1/3, state=LOST, move_ready=0.
REQ-047 After WON, move_valid held for 5 cycles -> no pulses; then restart together with move_valid -> start position, PLAY, no pulse on the following cycle.
REQ-048 256+ accepted moves, alternating shuttle (0,1)(0,1) -> move_count holds at 255; reset asserted with a pending accept -> no accept pulse appears.
